// File: rtl/guess_game_pkg.sv
// Shared types and constants for the number-guessing game controller:
// FSM states, compare-result flags and the LFSR tap table.
package guess_game_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_PLAY = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_t;

    // Result of the most recent guess; at most one bit is ever set.
    typedef struct packed {
        logic over;
        logic under;
        logic equal;
    } dp_t;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 16;
    localparam int TRIES_MIN = 1;
    localparam int TRIES_MAX = 255;

    // Maximal-length Fibonacci tap masks; bit n-1 set means tap n.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit cfg_ok(input int width, input int max_tries, input int unsigned seed);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (max_tries >= TRIES_MIN) && (max_tries <= TRIES_MAX) &&
               ((seed & ((32'd1 << width) - 32'd1)) != 32'd0);
    endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr.sv
// Free-running Fibonacci LFSR used as the secret source; a nonzero seed
// keeps it out of the all-zero lock-up state.
module lfsr_gen
    import guess_game_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int unsigned SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= SEED_W;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: compares guesses against a secret,
// counts down wrong attempts and reports win/lose.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          MAX_TRIES = 7,
    parameter bit          RANDOM    = 1'b1,
    parameter int unsigned SECRET    = 32'h0C,
    parameter int unsigned SEED      = 32'd1,
    localparam int         TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             new_game,
    input  logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] actual,
    output logic             dp_over,
    output logic             dp_under,
    output logic             dp_equal,
    output logic [TW-1:0]    tries_left,
    output logic             game_won,
    output logic             game_lost,
    output state_t           dbg_state
);

    localparam bit               CFG_OK     = cfg_ok(WIDTH, MAX_TRIES, SEED);
    localparam logic [WIDTH-1:0] SECRET_W   = WIDTH'(SECRET);
    localparam logic [TW-1:0]    TRIES_INIT = TW'(MAX_TRIES);

    if (!CFG_OK) begin : g_bad_cfg
        $error("guess_game_ctrl: WIDTH, MAX_TRIES or SEED out of range");
    end

    state_t           state_q, state_d;
    logic             enter_q, enter_d;
    logic [WIDTH-1:0] actual_q, actual_d;
    logic [TW-1:0]    tries_q, tries_d;
    dp_t              dp_q, dp_d;
    logic [WIDTH-1:0] lfsr_q;
    logic             press;

    lfsr_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_INIT;
            enter_q  <= 1'b0;
            actual_q <= '0;
            tries_q  <= TRIES_INIT;
            dp_q     <= '0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enter_d;
            actual_q <= actual_d;
            tries_q  <= tries_d;
            dp_q     <= dp_d;
        end
    end

    assign press   = enter & ~enter_q;
    assign enter_d = enter;

    // new_game takes priority over any press seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        actual_d = actual_q;
        tries_d  = tries_q;
        dp_d     = dp_q;
        if (new_game) begin
            state_d = S_INIT;
            dp_d    = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    actual_d = RANDOM ? lfsr_q : SECRET_W;
                    tries_d  = TRIES_INIT;
                    dp_d     = '0;
                    state_d  = S_PLAY;
                end
                S_PLAY: begin
                    if (press) begin
                        dp_d.over  = guess > actual_q;
                        dp_d.under = guess < actual_q;
                        dp_d.equal = guess == actual_q;
                        if (guess == actual_q) begin
                            state_d = S_WON;
                        end else if (tries_q > TW'(1)) begin
                            tries_d = tries_q - TW'(1);
                        end else begin
                            tries_d = '0;
                            state_d = S_LOST;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        actual     = actual_q;
        dp_over    = dp_q.over;
        dp_under   = dp_q.under;
        dp_equal   = dp_q.equal;
        tries_left = tries_q;
        game_won   = (state_q == S_WON);
        game_lost  = (state_q == S_LOST);
        dbg_state  = state_q;
    end

endmodule
